// File: rtl/sync_sp_ram_be_init.sv
// Synchronous single-port RAM with byte enables, post-reset zero-init sequencer and a read-valid strobe.
// Optional per-byte even parity is compiled in with `define SYNC_SP_RAM_PARITY_EN.
module sync_sp_ram_be_init #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_DEPTH = 1024,
  parameter int OUT_REGS   = 0
) (
  input  logic                    Clk_CI,
  input  logic                    Rst_RI,
  input  logic                    Req_SI,
  output logic                    Gnt_SO,
  input  logic                    WrEn_SI,
  input  logic [DATA_WIDTH/8-1:0] BEn_SI,
  input  logic [DATA_WIDTH-1:0]   WrData_DI,
  input  logic [ADDR_WIDTH-1:0]   Addr_DI,
  input  logic                    ParInj_SI,
  output logic                    RdValid_SO,
  output logic [DATA_WIDTH-1:0]   RdData_DO,
  output logic                    ParErr_SO,
  output logic                    InitDone_SO
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH + 1)'(DATA_DEPTH);

  typedef enum logic {INIT, READY} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  gnt_q;
  logic                  init_done_q;

  // NOTE: sequential state uses non-blocking <= so every register samples pre-edge values.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      gnt_q       <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR) begin
            state_q     <= READY;
            gnt_q       <= 1'b1;
            init_done_q <= 1'b1;
          end
        end
        READY:   state_q <= READY;
        default: state_q <= INIT;
      endcase
    end
  end

  logic acc, in_range, rd_acc;
  assign acc      = Req_SI & gnt_q;
  assign in_range = {1'b0, Addr_DI} < DEPTH_LIM;
  assign rd_acc   = acc & ~WrEn_SI;

  logic                  wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_d;
  logic [NB-1:0]         wr_ben_d;
  logic [NB-1:0]         wr_par_d;
  logic [NB-1:0]         wdata_par;

  always_comb begin
    wdata_par = '0;
    for (int b = 0; b < NB; b++) wdata_par[b] = ^WrData_DI[8*b +: 8];
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = Addr_DI;
    wr_data_d = WrData_DI;
    wr_ben_d  = BEn_SI;
    wr_par_d  = wdata_par ^ {NB{ParInj_SI}};
    if (state_q == INIT) begin
      wr_en_d   = 1'b1;
      wr_addr_d = cnt_q;
      wr_data_d = '0;
      wr_ben_d  = '1;
      wr_par_d  = '0;
    end else if (acc && WrEn_SI && in_range) begin
      wr_en_d = 1'b1;
    end
  end

  logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

  // NOTE: the storage array has no reset; the INIT sequencer clears it after every reset.
  always_ff @(posedge Clk_CI) begin
    if (wr_en_d) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_ben_d[b]) mem_q[wr_addr_d][8*b +: 8] <= wr_data_d[8*b +: 8];
      end
    end
  end

  logic [DATA_WIDTH-1:0] rd_word;
  logic                  par_mis;
  assign rd_word = in_range ? mem_q[Addr_DI] : '0;

`ifdef SYNC_SP_RAM_PARITY_EN
  logic [NB-1:0] par_mem_q [DATA_DEPTH];
  logic [NB-1:0] rd_par_calc;

  always_ff @(posedge Clk_CI) begin
    if (wr_en_d) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_ben_d[b]) par_mem_q[wr_addr_d][b] <= wr_par_d[b];
      end
    end
  end

  always_comb begin
    rd_par_calc = '0;
    for (int b = 0; b < NB; b++) rd_par_calc[b] = ^rd_word[8*b +: 8];
  end

  assign par_mis = in_range && (|(rd_par_calc ^ par_mem_q[Addr_DI]));
`else
  logic [NB:0] unused_par;
  assign unused_par = {ParInj_SI, wr_par_d};
  assign par_mis    = 1'b0;
`endif

  // Stage 1: data only moves on a valid, so the output holds between reads.
  logic                  rd_valid1_q, par_err1_q;
  logic [DATA_WIDTH-1:0] rd_data1_q;

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      rd_valid1_q <= 1'b0;
      rd_data1_q  <= '0;
      par_err1_q  <= 1'b0;
    end else begin
      rd_valid1_q <= rd_acc;
      par_err1_q  <= rd_acc & par_mis;
      if (rd_acc) rd_data1_q <= rd_word;
    end
  end

  generate
    if (OUT_REGS != 0) begin : g_out_reg
      logic                  rd_valid2_q, par_err2_q;
      logic [DATA_WIDTH-1:0] rd_data2_q;

      always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
          rd_valid2_q <= 1'b0;
          rd_data2_q  <= '0;
          par_err2_q  <= 1'b0;
        end else begin
          rd_valid2_q <= rd_valid1_q;
          par_err2_q  <= par_err1_q;
          if (rd_valid1_q) rd_data2_q <= rd_data1_q;
        end
      end

      assign RdValid_SO = rd_valid2_q;
      assign RdData_DO  = rd_data2_q;
      assign ParErr_SO  = par_err2_q;
    end else begin : g_no_out_reg
      assign RdValid_SO = rd_valid1_q;
      assign RdData_DO  = rd_data1_q;
      assign ParErr_SO  = par_err1_q;
    end
  endgenerate

  assign Gnt_SO      = gnt_q;
  assign InitDone_SO = init_done_q;

endmodule

// File: tb/tb_sync_sp_ram_be_init.sv
// Directed bench for sync_sp_ram_be_init: 12-word, 4-bit-address instance, expectations written by hand.
module tb_sync_sp_ram_be_init;

  localparam int DW       = 32;
  localparam int AW       = 4;
  localparam int DEPTH    = 12;
  localparam int OUT_REGS = 0;
  localparam int LAT      = OUT_REGS + 1;

`ifdef SYNC_SP_RAM_PARITY_EN
  localparam logic PAR_ON = 1'b1;
`else
  localparam logic PAR_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req, wr_en, par_inj;
  logic [3:0]    ben;
  logic [DW-1:0] wdata;
  logic [AW-1:0] addr;
  logic          gnt, rd_valid, par_err, init_done;
  logic [DW-1:0] rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_sp_ram_be_init #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_DEPTH(DEPTH), .OUT_REGS(OUT_REGS)
  ) dut (
    .Clk_CI(clk), .Rst_RI(rst), .Req_SI(req), .Gnt_SO(gnt), .WrEn_SI(wr_en),
    .BEn_SI(ben), .WrData_DI(wdata), .Addr_DI(addr), .ParInj_SI(par_inj),
    .RdValid_SO(rd_valid), .RdData_DO(rdata), .ParErr_SO(par_err), .InitDone_SO(init_done)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be, input logic inj);
    req = 1'b1; wr_en = 1'b1; addr = a; wdata = d; ben = be; par_inj = inj;
    tick();
    check("wr_no_valid", {31'b0, rd_valid}, 32'd0);
    req = 1'b0; wr_en = 1'b0; par_inj = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp, input logic exp_err);
    req = 1'b1; wr_en = 1'b0; addr = a;
    tick();
    req = 1'b0;
    for (int k = 0; k < LAT - 1; k++) begin
      check({tag, "_early_valid"}, {31'b0, rd_valid}, 32'd0);
      tick();
    end
    check({tag, "_valid"}, {31'b0, rd_valid}, 32'd1);
    check({tag, "_data"}, rdata, exp);
    check({tag, "_parerr"}, {31'b0, par_err}, {31'b0, exp_err});
    tick();
    check({tag, "_pulse_end"}, {31'b0, rd_valid}, 32'd0);
    check({tag, "_hold"}, rdata, exp);
    check({tag, "_parerr_idle"}, {31'b0, par_err}, 32'd0);
  endtask

  // Counts the INIT window: grant and init-done rise only after DEPTH edges.
  task automatic run_init(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      check({tag, "_gnt"}, {31'b0, gnt}, {31'b0, (i == DEPTH - 1)});
      check({tag, "_done"}, {31'b0, init_done}, {31'b0, (i == DEPTH - 1)});
      check({tag, "_no_valid"}, {31'b0, rd_valid}, 32'd0);
      if (i == DEPTH - 1) req = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req = 1'b0; wr_en = 1'b0; ben = '0; wdata = '0; addr = '0; par_inj = 1'b0;
    #12;
    check("rst_gnt", {31'b0, gnt}, 32'd0);
    check("rst_valid", {31'b0, rd_valid}, 32'd0);
    check("rst_data", rdata, 32'd0);
    check("rst_parerr", {31'b0, par_err}, 32'd0);
    check("rst_done", {31'b0, init_done}, 32'd0);

    // Init: requests held high throughout are ignored until grant.
    req = 1'b1; wr_en = 1'b0; addr = 4'd0;
    @(negedge clk);
    rst = 1'b0;
    run_init("init");
    for (int i = 0; i < DEPTH; i++) rd("init_zero", AW'(i), 32'h0, 1'b0);

    // Byte enables.
    wr(4'd5, 32'hAABBCCDD, 4'b1111, 1'b0);
    wr(4'd5, 32'h11223344, 4'b0101, 1'b0);
    rd("ben", 4'd5, 32'hAA22CC44, 1'b0);

    // BEn = 0 is a no-op write.
    wr(4'd8, 32'hDEADBEEF, 4'b0000, 1'b0);
    rd("ben_zero", 4'd8, 32'h0, 1'b0);

    // Streaming back-to-back reads.
    for (int i = 0; i < 8; i++) wr(AW'(i), DW'(32'h10 + i), 4'b1111, 1'b0);
    for (int i = 0; i < 8; i++) begin
      req = 1'b1; wr_en = 1'b0; addr = AW'(i);
      tick();
      if (i >= LAT - 1) begin
        check("stream_valid", {31'b0, rd_valid}, 32'd1);
        check("stream_data", rdata, DW'(32'h10 + i - (LAT - 1)));
      end
    end
    req = 1'b0;
    for (int i = 8 - (LAT - 1); i < 8; i++) begin
      tick();
      check("stream_tail_valid", {31'b0, rd_valid}, 32'd1);
      check("stream_tail_data", rdata, DW'(32'h10 + i));
    end
    tick();
    check("stream_end", {31'b0, rd_valid}, 32'd0);

    // Out of range: write dropped, read returns zero with a valid.
    wr(4'd13, 32'hFFFFFFFF, 4'b1111, 1'b0);
    rd("oor", 4'd13, 32'h0, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      rd("oor_keep", AW'(i), (i < 8) ? DW'(32'h10 + i) : 32'h0, 1'b0);

    // Parity injection on a single byte, then a clean rewrite.
    wr(4'd2, 32'h000000FF, 4'b0001, 1'b1);
    rd("par_inj", 4'd2, 32'h000000FF, PAR_ON);
    wr(4'd2, 32'h000000FF, 4'b0001, 1'b0);
    rd("par_clean", 4'd2, 32'h000000FF, 1'b0);

    // Reset right after an accepted read squashes it and restarts INIT.
    wr(4'd3, 32'h5A5A5A5A, 4'b1111, 1'b0);
    req = 1'b1; wr_en = 1'b0; addr = 4'd3;
    @(posedge clk);
    req = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_valid", {31'b0, rd_valid}, 32'd0);
    check("midrst_data", rdata, 32'd0);
    check("midrst_gnt", {31'b0, gnt}, 32'd0);
    tick();
    check("midrst_valid2", {31'b0, rd_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_init("reinit");
    rd("reinit_zero", 4'd3, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
